// File: rtl/alarm_ctrl_multi_if.sv
// Bundled time, alarm, control and status signals for alarm_ctrl_multi.
// master drives time/alarm/control inputs; slave is the controller.
interface alarm_ctrl_multi_if #(
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = 2
);
    logic                    minute_tick;
    logic [15:0]             current_time;
    logic [16*NUM_ALARMS-1:0] alarm_times;
    logic [NUM_ALARMS-1:0]   alarm_enable;
    logic                    do_snooze;
    logic                    stop_alarm;
    logic                    show_alarm;
    logic [IDX_W-1:0]        show_sel;
    logic [15:0]             display;
    logic                    sound_alarm;
    logic [IDX_W-1:0]        active_alarm;
    logic [15:0]             snooze_time;
    logic [3:0]              snooze_count;
    logic                    timed_out;
    logic [1:0]              state_out;

    modport master (
        output minute_tick, current_time, alarm_times, alarm_enable,
        output do_snooze, stop_alarm, show_alarm, show_sel,
        input  display, sound_alarm, active_alarm, snooze_time,
        input  snooze_count, timed_out, state_out
    );

    modport slave (
        input  minute_tick, current_time, alarm_times, alarm_enable,
        input  do_snooze, stop_alarm, show_alarm, show_sel,
        output display, sound_alarm, active_alarm, snooze_time,
        output snooze_count, timed_out, state_out
    );
endinterface

// File: rtl/alarm_ctrl_multi.sv
// Multi-slot BCD alarm controller with snooze, snooze limit and
// auto-off; drives one shared alarm output and the display mux.
module alarm_ctrl_multi #(
    parameter int NUM_ALARMS       = 4,
    parameter int SNOOZE_MIN       = 5,
    parameter int MAX_SNOOZES      = 3,
    parameter int RING_TIMEOUT_MIN = 10,
    parameter int IDX_W            = 2
) (
    input logic clk,
    input logic reset_n,
    alarm_ctrl_multi_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        RINGING     = 2'd1,
        SNOOZE_WAIT = 2'd2,
        BAD         = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] act_q, act_n;
    logic [15:0]      stime_q, stime_n;
    logic [3:0]       scnt_q, scnt_n;
    logic [7:0]       rcnt_q, rcnt_n;
    logic             tout_q, tout_n;
    logic             snd_q;

    logic             any_hit;
    logic             snz_hit;
    logic [IDX_W-1:0] winner;
    logic [15:0]      snz_sum;
    logic [6:0]       mins;
    logic [4:0]       hrs;

    // Lowest-index enabled slot matching the new minute wins.
    always_comb begin
        any_hit = 1'b0;
        winner  = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (bus.minute_tick && bus.alarm_enable[i] &&
                bus.current_time == bus.alarm_times[16*i +: 16]) begin
                any_hit = 1'b1;
                winner  = IDX_W'(i);
            end
        end
    end

    assign snz_hit = bus.minute_tick && (bus.current_time == stime_q);

    // BCD HH:MM plus SNOOZE_MIN with minute carry and 24h wrap.
    always_comb begin
        mins = 7'(bus.current_time[7:4]) * 7'd10
             + 7'(bus.current_time[3:0]) + 7'(SNOOZE_MIN);
        hrs  = 5'(bus.current_time[15:12]) * 5'd10
             + 5'(bus.current_time[11:8]);
        if (mins >= 7'd60) begin
            mins = mins - 7'd60;
            hrs  = hrs + 5'd1;
        end
        if (hrs >= 5'd24) begin
            hrs = hrs - 5'd24;
        end
        snz_sum = {4'(hrs / 5'd10), 4'(hrs % 5'd10),
                   4'(mins / 7'd10), 4'(mins % 7'd10)};
    end

    // Next-state and next-register values; stop beats snooze beats hits.
    always_comb begin
        state_n = state;
        act_n   = act_q;
        stime_n = stime_q;
        scnt_n  = scnt_q;
        rcnt_n  = rcnt_q;
        tout_n  = tout_q;
        case (state)
            IDLE: begin
                if (any_hit) begin
                    state_n = RINGING;
                    act_n   = winner;
                    scnt_n  = '0;
                    rcnt_n  = '0;
                    tout_n  = 1'b0;
                end
            end
            RINGING: begin
                if (bus.stop_alarm) begin
                    state_n = IDLE;
                    scnt_n  = '0;
                    tout_n  = 1'b0;
                end else if (bus.do_snooze) begin
                    if (scnt_q < 4'(MAX_SNOOZES)) begin
                        state_n = SNOOZE_WAIT;
                        stime_n = snz_sum;
                        scnt_n  = scnt_q + 4'd1;
                    end
                end else if (bus.minute_tick) begin
                    rcnt_n = rcnt_q + 8'd1;
                    if (rcnt_n == 8'(RING_TIMEOUT_MIN)) begin
                        state_n = IDLE;
                        tout_n  = 1'b1;
                    end
                end
            end
            SNOOZE_WAIT: begin
                if (bus.stop_alarm) begin
                    state_n = IDLE;
                    stime_n = '0;
                    scnt_n  = '0;
                    tout_n  = 1'b0;
                end else if (any_hit) begin
                    state_n = RINGING;
                    act_n   = winner;
                    scnt_n  = '0;
                    rcnt_n  = '0;
                    tout_n  = 1'b0;
                end else if (snz_hit) begin
                    state_n = RINGING;
                    rcnt_n  = '0;
                    tout_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                act_n   = '0;
                stime_n = '0;
                scnt_n  = '0;
                rcnt_n  = '0;
                tout_n  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            act_q   <= '0;
            stime_q <= '0;
            scnt_q  <= '0;
            rcnt_q  <= '0;
            tout_q  <= 1'b0;
            snd_q   <= 1'b0;
        end else begin
            state   <= state_n;
            act_q   <= act_n;
            stime_q <= stime_n;
            scnt_q  <= scnt_n;
            rcnt_q  <= rcnt_n;
            tout_q  <= tout_n;
            snd_q   <= (state_n == RINGING);
        end
    end

    // Display mux: selected slot or running time; out-of-range slot is blank.
    always_comb begin
        bus.display = bus.current_time;
        if (bus.show_alarm) begin
            bus.display = '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (32'(bus.show_sel) == i) begin
                    bus.display = bus.alarm_times[16*i +: 16];
                end
            end
        end
    end

    assign bus.sound_alarm  = snd_q;
    assign bus.active_alarm = act_q;
    assign bus.snooze_time  = stime_q;
    assign bus.snooze_count = scnt_q;
    assign bus.timed_out    = tout_q;
    assign bus.state_out    = state;
endmodule

// File: tb/tb_alarm_ctrl_multi.sv
// Scoreboard bench for alarm_ctrl_multi: stimulus queues expected
// status, a negedge monitor pops and compares.
module tb_alarm_ctrl_multi;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   step = 0;

    typedef struct {
        int          id;
        logic [1:0]  st;
        logic        snd;
        logic [1:0]  act;
        logic [15:0] stime;
        logic [3:0]  scnt;
        logic        tout;
        logic [15:0] disp;
    } exp_t;

    exp_t q[$];
    logic [15:0] slot[4];

    alarm_ctrl_multi_if #(.NUM_ALARMS(4), .IDX_W(2)) bus ();

    alarm_ctrl_multi #(
        .NUM_ALARMS(4), .SNOOZE_MIN(5), .MAX_SNOOZES(3),
        .RING_TIMEOUT_MIN(10), .IDX_W(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input int id, input string nm,
                       input logic [15:0] act, input logic [15:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL step%0d %s: got %h want %h", id, nm, act, ex);
        end
    endtask

    // Monitor: compare DUT status against every queued expectation.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.id, "state", 16'(bus.state_out), 16'(e.st));
            chk(e.id, "sound", 16'(bus.sound_alarm), 16'(e.snd));
            chk(e.id, "active", 16'(bus.active_alarm), 16'(e.act));
            chk(e.id, "snz_time", bus.snooze_time, e.stime);
            chk(e.id, "snz_cnt", 16'(bus.snooze_count), 16'(e.scnt));
            chk(e.id, "timed_out", 16'(bus.timed_out), 16'(e.tout));
            chk(e.id, "display", bus.display, e.disp);
        end
    end

    task automatic set_slots();
        bus.alarm_times = {slot[3], slot[2], slot[1], slot[0]};
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [15:0] t);
        bus.current_time = t;
        bus.minute_tick = 1'b1;
        cyc();
        bus.minute_tick = 1'b0;
    endtask

    task automatic push(input logic [1:0] st, input logic snd,
                        input logic [1:0] act, input logic [15:0] stime,
                        input logic [3:0] scnt, input logic tout,
                        input logic [15:0] disp);
        exp_t e;
        step++;
        e.id = step; e.st = st; e.snd = snd; e.act = act;
        e.stime = stime; e.scnt = scnt; e.tout = tout; e.disp = disp;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        bus.minute_tick = 1'b0;
        bus.current_time = 16'h0000;
        bus.alarm_enable = 4'b0001;
        bus.do_snooze = 1'b0;
        bus.stop_alarm = 1'b0;
        bus.show_alarm = 1'b0;
        bus.show_sel = 2'd0;
        slot[0] = 16'h0700; slot[1] = 16'h0630;
        slot[2] = 16'h0630; slot[3] = 16'h0702;
        set_slots();

        // reset and basic ring
        cyc(); cyc();
        push(2'd0, 0, 2'd0, 16'h0000, 4'd0, 0, 16'h0000);
        reset_n = 1'b1;
        tick(16'h0700);
        push(2'd1, 1, 2'd0, 16'h0000, 4'd0, 0, 16'h0700);
        bus.stop_alarm = 1'b1; cyc(); bus.stop_alarm = 1'b0;
        push(2'd0, 0, 2'd0, 16'h0000, 4'd0, 0, 16'h0700);

        // snooze across midnight
        slot[0] = 16'h2358; set_slots();
        tick(16'h2358);
        push(2'd1, 1, 2'd0, 16'h0000, 4'd0, 0, 16'h2358);
        bus.do_snooze = 1'b1; cyc(); bus.do_snooze = 1'b0;
        push(2'd2, 0, 2'd0, 16'h0003, 4'd1, 0, 16'h2358);
        tick(16'h0001);
        push(2'd2, 0, 2'd0, 16'h0003, 4'd1, 0, 16'h0001);
        tick(16'h0003);
        push(2'd1, 1, 2'd0, 16'h0003, 4'd1, 0, 16'h0003);

        // snooze limit then auto-off
        bus.do_snooze = 1'b1; cyc(); bus.do_snooze = 1'b0;
        push(2'd2, 0, 2'd0, 16'h0008, 4'd2, 0, 16'h0003);
        tick(16'h0008);
        bus.do_snooze = 1'b1; cyc(); bus.do_snooze = 1'b0;
        push(2'd2, 0, 2'd0, 16'h0013, 4'd3, 0, 16'h0008);
        tick(16'h0013);
        push(2'd1, 1, 2'd0, 16'h0013, 4'd3, 0, 16'h0013);
        bus.do_snooze = 1'b1; cyc(); bus.do_snooze = 1'b0;
        push(2'd1, 1, 2'd0, 16'h0013, 4'd3, 0, 16'h0013);
        for (int k = 0; k < 10; k++) begin
            tick(16'h0100 + 16'(k));
            if (k < 9)
                push(2'd1, 1, 2'd0, 16'h0013, 4'd3, 0, 16'h0100 + 16'(k));
            else
                push(2'd0, 0, 2'd0, 16'h0013, 4'd3, 1, 16'h0109);
        end

        // lowest slot wins; stop beats snooze
        bus.alarm_enable = 4'b0110;
        tick(16'h0630);
        push(2'd1, 1, 2'd1, 16'h0013, 4'd0, 0, 16'h0630);
        bus.do_snooze = 1'b1; bus.stop_alarm = 1'b1; cyc();
        bus.do_snooze = 1'b0; bus.stop_alarm = 1'b0;
        push(2'd0, 0, 2'd1, 16'h0013, 4'd0, 0, 16'h0630);

        // pre-emption by another slot, then no re-ring without tick
        slot[0] = 16'h0700; set_slots();
        bus.alarm_enable = 4'b1001;
        tick(16'h0700);
        push(2'd1, 1, 2'd0, 16'h0013, 4'd0, 0, 16'h0700);
        bus.do_snooze = 1'b1; cyc(); bus.do_snooze = 1'b0;
        push(2'd2, 0, 2'd0, 16'h0705, 4'd1, 0, 16'h0700);
        tick(16'h0701);
        push(2'd2, 0, 2'd0, 16'h0705, 4'd1, 0, 16'h0701);
        tick(16'h0702);
        push(2'd1, 1, 2'd3, 16'h0705, 4'd0, 0, 16'h0702);
        bus.stop_alarm = 1'b1; cyc(); bus.stop_alarm = 1'b0;
        push(2'd0, 0, 2'd3, 16'h0705, 4'd0, 0, 16'h0702);
        cyc(); cyc(); cyc();
        push(2'd0, 0, 2'd3, 16'h0705, 4'd0, 0, 16'h0702);
        tick(16'h0705);
        push(2'd0, 0, 2'd3, 16'h0705, 4'd0, 0, 16'h0705);

        // stop while snoozed clears snooze target
        tick(16'h0700);
        bus.do_snooze = 1'b1; cyc(); bus.do_snooze = 1'b0;
        push(2'd2, 0, 2'd0, 16'h0705, 4'd1, 0, 16'h0700);
        bus.stop_alarm = 1'b1; cyc(); bus.stop_alarm = 1'b0;
        push(2'd0, 0, 2'd0, 16'h0000, 4'd0, 0, 16'h0700);

        // reset while snoozed
        tick(16'h0700);
        bus.do_snooze = 1'b1; cyc(); bus.do_snooze = 1'b0;
        push(2'd2, 0, 2'd0, 16'h0705, 4'd1, 0, 16'h0700);
        reset_n = 1'b0; cyc(); reset_n = 1'b1;
        push(2'd0, 0, 2'd0, 16'h0000, 4'd0, 0, 16'h0700);

        // display mux
        bus.show_alarm = 1'b1; bus.show_sel = 2'd2;
        push(2'd0, 0, 2'd0, 16'h0000, 4'd0, 0, 16'h0630);
        bus.show_sel = 2'd3;
        push(2'd0, 0, 2'd0, 16'h0000, 4'd0, 0, 16'h0702);
        bus.show_alarm = 1'b0;
        push(2'd0, 0, 2'd0, 16'h0000, 4'd0, 0, 16'h0700);

        repeat (2) @(posedge clk);
        chk(0, "drain", 16'(q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
